// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and checksum helper for the UART frame deframer
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHECK,
    DRAIN
  } deframer_state_t;

  localparam logic [7:0] UART_SOF = 8'h7E;

  function automatic logic [7:0] chk8_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - pulls bytes from the UART rx FIFO, verifies length-prefixed frames, streams payloads
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF_BYTE       = UART_SOF,
  parameter int         TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_data_ready,
  input  logic [7:0]  rx_data,
  output logic        read_data,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        frame_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic        timeout_err,
  output logic [15:0] frame_count
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT_CYCLES - 1);

  deframer_state_t state, state_next;

  logic          pending;
  logic [7:0]    sum;
  logic [IW-1:0] len;
  logic [IW-1:0] idx;
  logic [IW-1:0] rd_idx;
  logic [TW-1:0] tcnt;
  logic [7:0]    buf_mem [MAX_LEN];

  logic capture, in_frame, timeout_now, len_bad, chk_ok, idx_last, rd_last, drain_hs;
  logic read_data_d, frame_ok_d, crc_err_d, len_err_d, timeout_err_d;

  // rx_data is valid exactly in the cycle after a pop, which is when pending is set
  assign capture     = pending;
  assign in_frame    = (state == LEN) || (state == PAYLOAD) || (state == CHECK);
  assign timeout_now = (TIMEOUT_CYCLES != 0) && in_frame && !capture && (tcnt == TLIMIT);
  assign len_bad     = (rx_data == 8'h00) || (int'(rx_data) > MAX_LEN);
  assign chk_ok      = (chk8_add(sum, rx_data) == 8'h00);
  assign idx_last    = (idx == len - IW'(1));
  assign rd_last     = (rd_idx == len - IW'(1));
  assign drain_hs    = m_valid && m_ready;

  assign m_data = m_valid ? buf_mem[rd_idx[AW-1:0]] : 8'h00;
  assign m_last = m_valid && rd_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HUNT: begin
        if (capture && rx_data == SOF_BYTE) state_next = LEN;
      end
      LEN: begin
        if (capture)          state_next = len_bad ? HUNT : PAYLOAD;
        else if (timeout_now) state_next = HUNT;
      end
      PAYLOAD: begin
        if (capture) begin
          if (idx_last) state_next = CHECK;
        end else if (timeout_now) begin
          state_next = HUNT;
        end
      end
      CHECK: begin
        if (capture)          state_next = chk_ok ? DRAIN : HUNT;
        else if (timeout_now) state_next = HUNT;
      end
      DRAIN: begin
        if (drain_hs && rd_last) state_next = HUNT;
      end
      default: state_next = HUNT;
    endcase
  end

  always_comb begin
    read_data_d   = (state_next != DRAIN) && rx_data_ready && !read_data && !timeout_now;
    frame_ok_d    = (state == CHECK) && capture && chk_ok;
    crc_err_d     = (state == CHECK) && capture && !chk_ok;
    len_err_d     = (state == LEN) && capture && len_bad;
    timeout_err_d = timeout_now;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data   <= 1'b0;
      pending     <= 1'b0;
      frame_ok    <= 1'b0;
      crc_err     <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= 16'h0000;
      m_valid     <= 1'b0;
      sum         <= 8'h00;
      len         <= '0;
      idx         <= '0;
      rd_idx      <= '0;
      tcnt        <= '0;
    end else begin
      read_data   <= read_data_d;
      pending     <= read_data && !timeout_now;
      frame_ok    <= frame_ok_d;
      crc_err     <= crc_err_d;
      len_err     <= len_err_d;
      timeout_err <= timeout_err_d;
      if (frame_ok_d && frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
      // stream opens the cycle after frame_ok, closes on the last handshake
      if (frame_ok)                 m_valid <= 1'b1;
      else if (drain_hs && rd_last) m_valid <= 1'b0;
      if (!in_frame || capture) tcnt <= '0;
      else                      tcnt <= tcnt + TW'(1);
      if (capture) begin
        case (state)
          HUNT:    sum <= 8'h00;
          LEN: begin
            len <= rx_data[IW-1:0];
            sum <= rx_data;
            idx <= '0;
          end
          PAYLOAD: begin
            sum <= chk8_add(sum, rx_data);
            idx <= idx + IW'(1);
          end
          CHECK:   rd_idx <= '0;
          default: ;
        endcase
      end
      if (drain_hs) rd_idx <= rd_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (capture && state == PAYLOAD) buf_mem[idx[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - self-checking bench for uart_rx_deframer
module tb_uart_rx_deframer;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_data_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        m_ready = 1'b0;
  logic        read_data, m_valid, m_last, frame_ok, crc_err, len_err, timeout_err;
  logic [7:0]  m_data;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  uart_rx_deframer #(.MAX_LEN(16), .SOF_BYTE(8'h7E), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .read_data(read_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .frame_ok(frame_ok), .crc_err(crc_err), .len_err(len_err),
    .timeout_err(timeout_err), .frame_count(frame_count)
  );

  typedef struct {
    int           n;
    logic [159:0] b;
    int           pl_off;
    int           pl_len;
    int           e_ok;
    int           e_crc;
    int           e_len;
  } vec_t;

  vec_t       vecs[9];
  logic [7:0] fifo[$];
  logic [8:0] sb[$];
  int errors = 0;
  int checks = 0;
  int n_ok = 0, n_crc = 0, n_len = 0, n_to = 0;
  int exp_fc = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // receiver FIFO model: pop on read_data, byte presented the following cycle
  always @(posedge clk) begin
    if (read_data && fifo.size() != 0) rx_data <= fifo.pop_front();
  end

  always @(negedge clk) rx_data_ready = (fifo.size() != 0);

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_ok)    n_ok++;
      if (crc_err)     n_crc++;
      if (len_err)     n_len++;
      if (timeout_err) n_to++;
      if (frame_ok || crc_err || len_err || timeout_err)
        chk("pulse_excl", 32'(frame_ok) + 32'(crc_err) + 32'(len_err) + 32'(timeout_err), 1);
      if (m_valid) chk("no_read_in_drain", read_data, 0);
      if (prev_stall) chk("stall_stable", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
      if (m_valid && m_ready) begin
        if (sb.size() == 0) chk("unexpected_byte", {m_last, m_data}, 9'h1FF);
        else                chk("stream_byte", {m_last, m_data}, sb.pop_front());
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] byte_at(input vec_t v, input int i);
    return v.b[8*(v.n-1-i) +: 8];
  endfunction

  task automatic wait_drained(input string name);
    for (int i = 0; i < 400 && fifo.size() != 0; i++) tick();
    chk(name, fifo.size() == 0, 1);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int ok0, crc0, len0, to0;
    ok0 = n_ok; crc0 = n_crc; len0 = n_len; to0 = n_to;
    if (v.e_ok != 0) begin
      for (int i = 0; i < v.pl_len; i++) sb.push_back({i == v.pl_len - 1, byte_at(v, v.pl_off + i)});
      exp_fc++;
    end
    for (int i = 0; i < v.n; i++) fifo.push_back(byte_at(v, i));
    m_ready = 1'b1;
    wait_drained($sformatf("v%0d_fifo", k));
    repeat (40) tick();
    chk($sformatf("v%0d_frame_ok", k), n_ok - ok0, v.e_ok);
    chk($sformatf("v%0d_crc_err", k), n_crc - crc0, v.e_crc);
    chk($sformatf("v%0d_len_err", k), n_len - len0, v.e_len);
    chk($sformatf("v%0d_timeout", k), n_to - to0, 0);
    chk($sformatf("v%0d_sb_empty", k), sb.size(), 0);
    chk($sformatf("v%0d_frame_count", k), frame_count, exp_fc);
  endtask

  initial begin
    int ok0, to0, held;
    vecs[0] = '{6,  160'h7E0311223397, 2, 3, 1, 0, 0};
    vecs[1] = '{6,  160'h7E0311223398, 0, 0, 0, 1, 0};
    vecs[2] = '{4,  160'h7E01AA55, 2, 1, 1, 0, 0};
    vecs[3] = '{2,  160'h7E00, 0, 0, 0, 0, 1};
    vecs[4] = '{2,  160'h7E11, 0, 0, 0, 0, 1};
    vecs[5] = '{4,  160'h7E0105FA, 2, 1, 1, 0, 0};
    vecs[6] = '{7,  160'h00FF7E7E01AA55, 0, 0, 0, 0, 1};
    vecs[7] = '{5,  160'h7E027E1070, 2, 2, 1, 0, 0};
    vecs[8] = '{19, 160'h7E100102030405060708090A0B0C0D0E0F1068, 2, 16, 1, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst_outputs", {read_data, m_valid, m_last, m_data, frame_ok, crc_err, len_err, timeout_err}, 0);
    chk("rst_frame_count", frame_count, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 9; k++) run_vec(k, vecs[k]);

    // backpressure: first frame stalls in DRAIN while the next frame waits in the FIFO
    m_ready = 1'b0;
    ok0 = n_ok;
    sb.push_back({1'b0, 8'h11}); sb.push_back({1'b0, 8'h22}); sb.push_back({1'b1, 8'h33});
    sb.push_back({1'b1, 8'hAA});
    exp_fc += 2;
    foreach (vecs[0].b[i]) if (0) ;
    for (int i = 0; i < 6; i++) fifo.push_back(byte_at(vecs[0], i));
    for (int i = 0; i < 4; i++) fifo.push_back(byte_at(vecs[2], i));
    for (int i = 0; i < 200 && !m_valid; i++) tick();
    chk("bp_valid", m_valid, 1);
    held = fifo.size();
    repeat (50) tick();
    chk("bp_fifo_held", fifo.size(), held);
    chk("bp_data_held", {m_valid, m_last, m_data}, {1'b1, 1'b0, 8'h11});
    m_ready = 1'b1;
    wait_drained("bp_fifo");
    repeat (40) tick();
    chk("bp_frames", n_ok - ok0, 2);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_frame_count", frame_count, exp_fc);

    // inter-byte timeout mid-payload
    to0 = n_to;
    ok0 = n_ok;
    fifo.push_back(8'h7E); fifo.push_back(8'h02); fifo.push_back(8'h11);
    wait_drained("to_fifo");
    repeat (TO + 20) tick();
    chk("to_pulse", n_to - to0, 1);
    chk("to_no_frame", n_ok - ok0, 0);
    chk("to_valid_low", m_valid, 0);
    run_vec(9, vecs[0]);

    // reset mid-payload
    fifo.push_back(8'h7E); fifo.push_back(8'h05); fifo.push_back(8'h01); fifo.push_back(8'h02);
    wait_drained("rst_fifo");
    repeat (3) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_outputs", {read_data, m_valid, m_last, m_data, frame_ok, crc_err, len_err, timeout_err}, 0);
    chk("mid_rst_frame_count", frame_count, 0);
    exp_fc = 0;
    tick();
    rst_n = 1'b1;
    tick();
    run_vec(10, vecs[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
